// File: rtl/icache_set_assoc_if.sv
// Fetch-side and memory-side handshake bundle for icache_set_assoc.
// master = the cache, slave = the InsFetch/MemCtrl side.
interface icache_set_assoc_if;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic        hit;
    logic [31:0] hit_inst;
    logic        mem_ask;
    logic [31:0] mem_addr;
    logic        mem_valid;
    logic [31:0] mem_inst;

    modport master (
        input  fetch_valid, fetch_pc, mem_valid, mem_inst,
        output hit, hit_inst, mem_ask, mem_addr
    );

    modport slave (
        output fetch_valid, fetch_pc, mem_valid, mem_inst,
        input  hit, hit_inst, mem_ask, mem_addr
    );
endinterface

// File: rtl/icache_set_assoc.sv
// Set-associative (1 or 2 way) instruction cache with LRU replacement and burst line refill.
// Optional hit/miss counters when ICACHE_STATS_EN is defined.
module icache_set_assoc #(
    parameter int WAYS     = 2,
    parameter int SET_BITS = 5,
    parameter int OFF_BITS = 2,
    parameter int ADDR_HI  = 17
) (
    input  logic                clk_in,
    input  logic                rst_n_in,
    input  logic                rdy_in,
    input  logic                flush_in,
    icache_set_assoc_if.master  bus
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]         stat_hits,
    output logic [31:0]         stat_misses
`endif
);
    localparam int SETS   = 1 << SET_BITS;
    localparam int WORDS  = 1 << OFF_BITS;
    localparam int IDX_LO = OFF_BITS + 2;
    localparam int TAG_LO = SET_BITS + OFF_BITS + 2;
    localparam int TAG_W  = ADDR_HI - TAG_LO + 1;

    typedef enum logic {IDLE, REFILL} state_t;

    state_t                       state_q, state_d;
    logic [OFF_BITS-1:0]          beat_q, beat_d, beat_nxt;
    logic [31:0]                  base_q, base_d;
    logic [TAG_W-1:0]             tag_lat_q, tag_lat_d;
    logic [SET_BITS-1:0]          set_lat_q, set_lat_d;
    logic                         victim_q, victim_d;
    logic                         hit_q, hit_d;
    logic [31:0]                  hit_inst_q, hit_inst_d;
    logic                         mem_ask_q, mem_ask_d;
    logic [31:0]                  mem_addr_q, mem_addr_d;
    logic [WAYS-1:0][SETS-1:0]    valid_q, valid_d;
    logic [SETS-1:0]              lru_q, lru_d;

    logic [31:0]                  data_q [WAYS][SETS][WORDS];
    logic [TAG_W-1:0]             tag_q  [WAYS][SETS];
    logic                         data_we, tag_we;

    logic [SET_BITS-1:0]          lk_set;
    logic [TAG_W-1:0]             lk_tag;
    logic [OFF_BITS-1:0]          lk_word;
    logic [31:0]                  lk_base;
    logic                         lk_hit, lk_way, lk_victim;
    logic                         unused_pc_lsb;

    assign lk_set        = bus.fetch_pc[TAG_LO-1:IDX_LO];
    assign lk_tag        = bus.fetch_pc[ADDR_HI:TAG_LO];
    assign lk_word       = bus.fetch_pc[IDX_LO-1:2];
    assign lk_base       = {bus.fetch_pc[31:IDX_LO], {IDX_LO{1'b0}}};
    assign beat_nxt      = beat_q + 1'b1;
    assign unused_pc_lsb = ^bus.fetch_pc[1:0];

    always_comb begin
        lk_hit = 1'b0;
        lk_way = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[w][lk_set] && tag_q[w][lk_set] == lk_tag) begin
                lk_hit = 1'b1;
                lk_way = 1'(w);
            end
        end
        // Fill an empty way before evicting; otherwise take the LRU way.
        lk_victim = 1'b0;
        if (WAYS == 2) begin
            if (!valid_q[0][lk_set])             lk_victim = 1'b0;
            else if (!valid_q[WAYS-1][lk_set])   lk_victim = 1'b1;
            else                                 lk_victim = lru_q[lk_set];
        end
    end

    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        base_d     = base_q;
        tag_lat_d  = tag_lat_q;
        set_lat_d  = set_lat_q;
        victim_d   = victim_q;
        hit_d      = hit_q;
        hit_inst_d = hit_inst_q;
        mem_ask_d  = mem_ask_q;
        mem_addr_d = mem_addr_q;
        valid_d    = valid_q;
        lru_d      = lru_q;
        data_we    = 1'b0;
        tag_we     = 1'b0;
        if (rdy_in) begin
            hit_d = 1'b0;
            if (flush_in) begin
                valid_d    = '0;
                lru_d      = '0;
                state_d    = IDLE;
                mem_ask_d  = 1'b0;
                mem_addr_d = '0;
                beat_d     = '0;
            end else if (state_q == IDLE) begin
                if (bus.fetch_valid) begin
                    if (lk_hit) begin
                        hit_d      = 1'b1;
                        hit_inst_d = data_q[lk_way][lk_set][lk_word];
                        if (WAYS == 2) lru_d[lk_set] = ~lk_way;
                    end else begin
                        base_d     = lk_base;
                        tag_lat_d  = lk_tag;
                        set_lat_d  = lk_set;
                        victim_d   = lk_victim;
                        mem_ask_d  = 1'b1;
                        mem_addr_d = lk_base;
                        beat_d     = '0;
                        state_d    = REFILL;
                    end
                end
            end else if (bus.mem_valid) begin
                data_we = 1'b1;
                if (beat_q == '1) begin
                    tag_we                       = 1'b1;
                    valid_d[victim_q][set_lat_q] = 1'b1;
                    if (WAYS == 2) lru_d[set_lat_q] = ~victim_q;
                    mem_ask_d  = 1'b0;
                    mem_addr_d = '0;
                    beat_d     = '0;
                    state_d    = IDLE;
                end else begin
                    beat_d     = beat_nxt;
                    mem_addr_d = base_q | {{(30-OFF_BITS){1'b0}}, beat_nxt, 2'b00};
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q    <= IDLE;
            beat_q     <= '0;
            base_q     <= '0;
            tag_lat_q  <= '0;
            set_lat_q  <= '0;
            victim_q   <= 1'b0;
            hit_q      <= 1'b0;
            hit_inst_q <= '0;
            mem_ask_q  <= 1'b0;
            mem_addr_q <= '0;
            valid_q    <= '0;
            lru_q      <= '0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            base_q     <= base_d;
            tag_lat_q  <= tag_lat_d;
            set_lat_q  <= set_lat_d;
            victim_q   <= victim_d;
            hit_q      <= hit_d;
            hit_inst_q <= hit_inst_d;
            mem_ask_q  <= mem_ask_d;
            mem_addr_q <= mem_addr_d;
            valid_q    <= valid_d;
            lru_q      <= lru_d;
        end
    end

    // Storage arrays carry no reset; the valid bits guard every read.
    always_ff @(posedge clk_in) begin
        if (data_we) data_q[victim_q][set_lat_q][beat_q] <= bus.mem_inst;
        if (tag_we)  tag_q[victim_q][set_lat_q]          <= tag_lat_q;
    end

    assign bus.hit      = hit_q;
    assign bus.hit_inst = hit_inst_q;
    assign bus.mem_ask  = mem_ask_q;
    assign bus.mem_addr = mem_addr_q;

`ifdef ICACHE_STATS_EN
    logic [31:0] stat_hits_q, stat_hits_d, stat_misses_q, stat_misses_d;
    logic        lookup_en;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    assign lookup_en = rdy_in && !flush_in && state_q == IDLE && bus.fetch_valid;

    always_comb begin
        stat_hits_d   = stat_hits_q;
        stat_misses_d = stat_misses_q;
        if (lookup_en &&  lk_hit) stat_hits_d   = sat_inc(stat_hits_q);
        if (lookup_en && !lk_hit) stat_misses_d = sat_inc(stat_misses_q);
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            stat_hits_q   <= '0;
            stat_misses_q <= '0;
        end else begin
            stat_hits_q   <= stat_hits_d;
            stat_misses_q <= stat_misses_d;
        end
    end

    assign stat_hits   = stat_hits_q;
    assign stat_misses = stat_misses_q;
`endif
endmodule

// File: tb/tb_icache_set_assoc.sv
// Directed bench for icache_set_assoc (WAYS=2, SET_BITS=5, OFF_BITS=2); memory returns word = address.
module tb_icache_set_assoc;
    logic clk = 1'b0;
    logic rst_n, rdy, flush;
    int   pass_cnt = 0;
    int   chk_cnt  = 0;

    icache_set_assoc_if bus();

`ifdef ICACHE_STATS_EN
    logic [31:0] stat_hits, stat_misses;
`endif

    icache_set_assoc #(.WAYS(2), .SET_BITS(5), .OFF_BITS(2), .ADDR_HI(17)) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .rdy_in   (rdy),
        .flush_in (flush),
        .bus      (bus)
`ifdef ICACHE_STATS_EN
        ,
        .stat_hits   (stat_hits),
        .stat_misses (stat_misses)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Miss on pc, serve four beats (word = address), then expect the post-refill hit.
    task automatic miss_refill(input logic [31:0] pc);
        logic [31:0] base;
        base = pc & ~32'hF;
        bus.fetch_valid = 1'b1;
        bus.fetch_pc    = pc;
        tick();
        chk_cnt++;
        if (bus.mem_ask !== 1'b1 || bus.hit !== 1'b0)
            $display("FAIL miss_start %h: ask=%b hit=%b want ask=1 hit=0", pc, bus.mem_ask, bus.hit);
        else pass_cnt++;
        for (int k = 0; k < 4; k++) begin
            chk_cnt++;
            if (bus.mem_addr !== base + 32'(4 * k))
                $display("FAIL refill_addr %h beat%0d: got %h want %h", pc, k, bus.mem_addr, base + 32'(4 * k));
            else pass_cnt++;
            bus.mem_valid = 1'b1;
            bus.mem_inst  = base + 32'(4 * k);
            tick();
            bus.mem_valid = 1'b0;
        end
        chk_cnt++;
        if (bus.mem_ask !== 1'b0 || bus.mem_addr !== 32'h0 || bus.hit !== 1'b0)
            $display("FAIL refill_end %h: ask=%b addr=%h hit=%b want 0/0/0", pc, bus.mem_ask, bus.mem_addr, bus.hit);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if (bus.hit !== 1'b1 || bus.hit_inst !== pc)
            $display("FAIL post_refill_hit %h: hit=%b inst=%h want 1/%h", pc, bus.hit, bus.hit_inst, pc);
        else pass_cnt++;
        bus.fetch_valid = 1'b0;
    endtask

    task automatic expect_hit(input logic [31:0] pc);
        bus.fetch_valid = 1'b1;
        bus.fetch_pc    = pc;
        tick();
        chk_cnt++;
        if (bus.hit !== 1'b1 || bus.hit_inst !== pc || bus.mem_ask !== 1'b0)
            $display("FAIL hit %h: hit=%b inst=%h ask=%b want 1/%h/0", pc, bus.hit, bus.hit_inst, bus.mem_ask, pc);
        else pass_cnt++;
        bus.fetch_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; rdy = 1'b1; flush = 1'b0;
        bus.fetch_valid = 1'b0; bus.fetch_pc = '0; bus.mem_valid = 1'b0; bus.mem_inst = '0;
        tick(); tick();
        chk_cnt++;
        if (bus.hit !== 1'b0 || bus.hit_inst !== 32'h0 || bus.mem_ask !== 1'b0 || bus.mem_addr !== 32'h0)
            $display("FAIL reset: hit=%b inst=%h ask=%b addr=%h want all 0", bus.hit, bus.hit_inst, bus.mem_ask, bus.mem_addr);
        else pass_cnt++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_cold_miss;
        miss_refill(32'h100);
    endtask

    task automatic test_hit_same_line;
        expect_hit(32'h108);
        tick();
        chk_cnt++;
        if (bus.hit !== 1'b0)
            $display("FAIL idle_no_fetch: hit=%b want 0", bus.hit);
        else pass_cnt++;
    endtask

`ifdef ICACHE_STATS_EN
    task automatic test_stats;
        chk_cnt++;
        if (stat_misses !== 32'd1 || stat_hits !== 32'd2)
            $display("FAIL stats: hits=%0d misses=%0d want 2/1", stat_hits, stat_misses);
        else pass_cnt++;
    endtask
`endif

    task automatic test_conflict;
        miss_refill(32'h900);
        expect_hit(32'h100);
        miss_refill(32'h1100);
        expect_hit(32'h100);
        miss_refill(32'h900);
        expect_hit(32'h104);
    endtask

    task automatic test_flush_mid_refill;
        bus.fetch_valid = 1'b1;
        bus.fetch_pc    = 32'h200;
        tick();
        for (int k = 0; k < 2; k++) begin
            bus.mem_valid = 1'b1;
            bus.mem_inst  = 32'h200 + 32'(4 * k);
            tick();
        end
        chk_cnt++;
        if (bus.mem_addr !== 32'h208 || bus.mem_ask !== 1'b1)
            $display("FAIL flush_pre: addr=%h ask=%b want 208/1", bus.mem_addr, bus.mem_ask);
        else pass_cnt++;
        bus.mem_inst = 32'h208;
        flush        = 1'b1;
        tick();
        flush         = 1'b0;
        bus.mem_valid = 1'b0;
        chk_cnt++;
        if (bus.mem_ask !== 1'b0 || bus.mem_addr !== 32'h0 || bus.hit !== 1'b0)
            $display("FAIL flush_abort: ask=%b addr=%h hit=%b want 0/0/0", bus.mem_ask, bus.mem_addr, bus.hit);
        else pass_cnt++;
        miss_refill(32'h100);
        miss_refill(32'h200);
    endtask

    task automatic test_rdy_stall;
        bus.fetch_valid = 1'b1;
        bus.fetch_pc    = 32'h300;
        tick();
        bus.mem_valid = 1'b1;
        bus.mem_inst  = 32'h300;
        tick();
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.mem_inst = 32'hDEAD_0000 + 32'(i);
            tick();
            chk_cnt++;
            if (bus.mem_addr !== 32'h304 || bus.mem_ask !== 1'b1)
                $display("FAIL stall%0d: addr=%h ask=%b want 304/1", i, bus.mem_addr, bus.mem_ask);
            else pass_cnt++;
        end
        rdy = 1'b1;
        for (int k = 1; k < 4; k++) begin
            chk_cnt++;
            if (bus.mem_addr !== 32'h300 + 32'(4 * k))
                $display("FAIL resume beat%0d: addr=%h want %h", k, bus.mem_addr, 32'h300 + 32'(4 * k));
            else pass_cnt++;
            bus.mem_inst = 32'h300 + 32'(4 * k);
            tick();
        end
        bus.mem_valid = 1'b0;
        tick();
        chk_cnt++;
        if (bus.hit !== 1'b1 || bus.hit_inst !== 32'h300)
            $display("FAIL stall_hit: hit=%b inst=%h want 1/300", bus.hit, bus.hit_inst);
        else pass_cnt++;
        bus.fetch_valid = 1'b0;
        expect_hit(32'h304);
        expect_hit(32'h30C);
    endtask

    task automatic test_rdy_hold;
        bus.fetch_valid = 1'b1;
        bus.fetch_pc    = 32'h304;
        tick();
        rdy          = 1'b0;
        bus.fetch_pc = 32'h400;
        tick(); tick();
        chk_cnt++;
        if (bus.hit !== 1'b1 || bus.hit_inst !== 32'h304 || bus.mem_ask !== 1'b0)
            $display("FAIL rdy_hold: hit=%b inst=%h ask=%b want 1/304/0", bus.hit, bus.hit_inst, bus.mem_ask);
        else pass_cnt++;
        rdy             = 1'b1;
        bus.fetch_valid = 1'b0;
        tick();
    endtask

    task automatic test_flush_vs_lookup;
        bus.fetch_valid = 1'b1;
        bus.fetch_pc    = 32'h300;
        flush           = 1'b1;
        tick();
        flush = 1'b0;
        chk_cnt++;
        if (bus.hit !== 1'b0 || bus.mem_ask !== 1'b0)
            $display("FAIL flush_lookup: hit=%b ask=%b want 0/0", bus.hit, bus.mem_ask);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if (bus.mem_ask !== 1'b1 || bus.mem_addr !== 32'h300 || bus.hit !== 1'b0)
            $display("FAIL flushed_miss: ask=%b addr=%h hit=%b want 1/300/0", bus.mem_ask, bus.mem_addr, bus.hit);
        else pass_cnt++;
        bus.fetch_valid = 1'b0;
        flush           = 1'b1;
        tick();
        flush = 1'b0;
        chk_cnt++;
        if (bus.mem_ask !== 1'b0 || bus.mem_addr !== 32'h0)
            $display("FAIL flush_idle_refill: ask=%b addr=%h want 0/0", bus.mem_ask, bus.mem_addr);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_hit_same_line();
`ifdef ICACHE_STATS_EN
        test_stats();
`endif
        test_conflict();
        test_flush_mid_refill();
        test_rdy_stall();
        test_rdy_hold();
        test_flush_vs_lookup();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
